// File: rtl/router_out_ctrl.sv
// router_out_ctrl: read side of one 1x3 router output port (FIFO drain, re-framing, stall flush).
// Parity checking is built only when ROUTER_OUT_PARITY_CHECK_EN is defined; otherwise parity_err is 0.
module router_out_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_read_enb,
  output logic        fifo_soft_reset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        parity_err,
  output logic        timeout_err,
  output logic [15:0] pkt_count,
  output logic [1:0]  debug_state
);

  // Handshake: a byte moves downstream in every cycle where out_valid && out_ready;
  // out_valid/out_data/out_sop/out_eop hold steady until that transfer, except on a stall flush.

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  typedef struct packed {
`ifdef ROUTER_OUT_PARITY_CHECK_EN
    logic       perr;
`endif
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

  state_t     state;
  logic [5:0] remaining;
  logic [1:0] occ;
  logic       inflight;
  entry_t     head_q;
  entry_t     tail_q;
  entry_t     cap_entry;
  logic [7:0] stall_cnt;
  logic       timeout_q;

  logic       pop;
  logic       capture;
  logic       stall;
  logic       stall_hit;
  logic [2:0] pending;
  logic [1:0] wr_slot;

`ifdef ROUTER_OUT_PARITY_CHECK_EN
  logic [7:0] run_par;
  logic       perr_pulse_q;
`endif

  assign out_valid       = (occ != 2'd0);
  assign out_data        = head_q.data;
  assign out_sop         = head_q.sop;
  assign out_eop         = head_q.eop;
  assign fifo_soft_reset = timeout_q;
  assign timeout_err     = timeout_q;
  assign debug_state     = state;

  assign pop     = out_valid && out_ready;
  assign capture = inflight;
  assign stall   = out_valid && !out_ready;
  assign stall_hit = stall && (stall_cnt == 8'(TIMEOUT - 1));

  // Entries the buffer will have to hold once this cycle's pop and any in-flight byte settle.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_read_enb = !reset && !fifo_empty && !timeout_q && (pending < 3'd2);

  // Slot the captured byte lands in, after this cycle's pop has shifted the buffer.
  assign wr_slot = occ - {1'b0, pop};

  always_comb begin
    cap_entry      = '0;
    cap_entry.data = fifo_data;
    cap_entry.sop  = (state == S_HDR);
    cap_entry.eop  = (state == S_PARITY);
`ifdef ROUTER_OUT_PARITY_CHECK_EN
    cap_entry.perr = (state == S_PARITY) && (fifo_data != run_par);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_HDR;
      remaining <= 6'd0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      stall_cnt <= 8'd0;
      timeout_q <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      timeout_q <= stall_hit;
      if (pop && head_q.eop) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (stall_hit) begin
        // Flush: drop buffered bytes and the byte returning next cycle, restart framing.
        state     <= S_HDR;
        remaining <= 6'd0;
        occ       <= 2'd0;
        inflight  <= 1'b0;
        head_q    <= '0;
        tail_q    <= '0;
        stall_cnt <= 8'd0;
      end else begin
        inflight  <= fifo_read_enb;
        stall_cnt <= stall ? (stall_cnt + 8'd1) : 8'd0;
        occ       <= occ - {1'b0, pop} + {1'b0, capture};
        if (pop) begin
          head_q <= tail_q;
        end
        if (capture) begin
          if (wr_slot == 2'd0) begin
            head_q <= cap_entry;
          end else begin
            tail_q <= cap_entry;
          end
          case (state)
            S_HDR: begin
              remaining <= fifo_data[7:2];
              state     <= (fifo_data[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
            end
            S_PAYLOAD: begin
              remaining <= remaining - 6'd1;
              if (remaining == 6'd1) begin
                state <= S_PARITY;
              end
            end
            default: begin
              state <= S_HDR;
            end
          endcase
        end
      end
    end
  end

`ifdef ROUTER_OUT_PARITY_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      run_par      <= 8'h00;
      perr_pulse_q <= 1'b0;
    end else begin
      perr_pulse_q <= pop && head_q.eop && head_q.perr;
      if (capture && !stall_hit) begin
        if (state == S_HDR) begin
          run_par <= fifo_data;
        end else if (state == S_PAYLOAD) begin
          run_par <= run_par ^ fifo_data;
        end
      end
    end
  end
  assign parity_err = perr_pulse_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/router_out_ctrl.md
# router_out_ctrl

Read-side controller for one destination port of the 1x3 router. Drains packets from that port's router FIFO, whose registered data output is valid one cycle after a read. Re-frames each packet with start/end markers and checks its parity. Presents bytes downstream on a valid/ready handshake, and raises the FIFO's soft reset when the destination stalls too long.

## Interface

- TIMEOUT, 30, consecutive stalled cycles (out_valid=1, out_ready=0) before flush; legal range 2..255
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  8  FIFO data_out, valid the cycle after a read
- fifo_read_enb  out  1  FIFO read enable
- fifo_soft_reset  out  1  one-cycle FIFO flush pulse
- out_valid  out  1  out_data/out_sop/out_eop valid
- out_ready  in  1  downstream accepts byte this cycle
- out_data  out  8  packet byte
- out_sop  out  1  byte is header
- out_eop  out  1  byte is parity byte
- parity_err  out  1  one-cycle pulse on bad-parity eop transfer
- timeout_err  out  1  one-cycle pulse coincident with fifo_soft_reset
- pkt_count  out  16  packets completed (eop transfers), wraps at 0xFFFF->0

## Operation

- Packet format: header (bits[7:2] = payload length L, 0..63; bits[1:0] = address), then L payload bytes, then parity byte. Total length is L+2.
- Parity byte = XOR of header and all payload bytes.
- Two-entry output skid buffer; occ = entries held (0..2). inflight = 1 if a read was issued last cycle.
- fifo_read_enb = !fifo_empty && !fifo_soft_reset && (occ + inflight - pop < 2), where pop = out_valid && out_ready. This term is combinational.
- A byte returned on fifo_data is always captured. The buffer never overflows.
- Parse FSM runs on captured bytes:
  - HDR: tag sop, load remaining = bits[7:2], load running parity = byte. Go to PAYLOAD if L>0, else PARITY.
  - PAYLOAD: XOR into running parity, decrement remaining. Go to PARITY when remaining reaches 0.
  - PARITY: tag eop, store mismatch flag (byte != running parity). Return to HDR.
- out_data is the head of the buffer, in order. Tags travel with their bytes.
- On a transfer with out_eop=1: pkt_count increments, and parity_err pulses if the stored flag is set.
- Stall counter: counts cycles with out_valid && !out_ready; clears on any transfer or when out_valid=0.
- Timeout, when the counter reaches TIMEOUT:
  - fifo_soft_reset and timeout_err pulse for one cycle.
  - Buffer is flushed and any in-flight byte discarded.
  - FSM goes to HDR and the stall counter clears.
  - pkt_count is unchanged.
- Reset values: fifo_read_enb 0, fifo_soft_reset 0, out_valid 0, out_data 8'h00, out_sop 0, out_eop 0, parity_err 0, timeout_err 0, pkt_count 0; FSM in HDR.
- Reset mid-packet discards all partial state, including in-flight data.

## Timing

- Latency: fifo_read_enb issued in cycle n, data on fifo_data in n+1, out_valid in n+2.
- With out_ready held 1 and the FIFO non-empty, out_valid stays high and one byte transfers per cycle.
- Pop and capture in the same cycle: occ stays unchanged and head advances.
- The timeout pulse is asserted in the cycle in which the stall counter would otherwise reach TIMEOUT. out_valid=0 in the following cycle.
- fifo_read_enb = 0 during the pulse cycle. Reads resume the cycle after.
- parity_err and timeout_err are registered, asserted the cycle after the qualifying event.

## Configuration

- ROUTER_OUT_PARITY_CHECK_EN defined: parity is checked as above.
- Not defined: no running parity, no mismatch flag; parity_err is tied 0. The parity byte is still forwarded with eop, and framing is unchanged.

## Test plan

- FIFO holds 0x0D,0x11,0x22,0x33,0x0D; out_ready=1 -> five consecutive transfers, sop on first, eop on last, parity_err 0, pkt_count 1.
- Same packet with last byte 0x0C -> eop transfer followed next cycle by a one-cycle parity_err; pkt_count 1.
- Header 0x00 with parity 0x00 -> two-byte packet, sop on byte 0, eop on byte 1, no error.
- out_ready=0 with a byte held for 30 cycles -> fifo_soft_reset and timeout_err pulse once, out_valid 0 next cycle, no fifo_read_enb that cycle.
- out_ready toggling 1/0 across a 20-byte packet -> bytes delivered in order, none lost or duplicated, fifo_read_enb never asserted with occ+inflight=2 and no pop.
- reset asserted mid-payload, then a fresh packet -> outputs at reset values, new packet framed correctly from its header, pkt_count 1.
